// File: rtl/sim_check_pkg.sv
// Shared types and width helpers for the simulation result checker.
// Imported by the checker top and its expected-value store.
package sim_check_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int tmr_w(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/sim_result_checker_if.sv
// Expected-value load port and observed-bus port of the checker.
// master drives (bench or board top), slave is the checker.
interface sim_result_checker_if #(
    parameter int WIDTH = 32
);

    logic             exp_we;
    logic [WIDTH-1:0] exp_wdata;
    logic             obs_valid;
    logic [WIDTH-1:0] obs_data;

    modport master (
        output exp_we,
        output exp_wdata,
        output obs_valid,
        output obs_data
    );

    modport slave (
        input exp_we,
        input exp_wdata,
        input obs_valid,
        input obs_data
    );

endinterface

// File: rtl/sim_expect_mem.sv
// Expected-value store: synchronous write, combinational read.
// Contents are not reset; only entries below exp_count are ever read.
module sim_expect_mem
    import sim_check_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Append port used while the list is being loaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sim_result_checker.sv
// Compares an observed CPU output bus against a loaded list of
// expected values, in order, with a no-progress timeout.
module sim_result_checker
    import sim_check_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 1000000,
    parameter int CHANGE_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     start,
    sim_result_checker_if.slave      bus,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [$clog2(DEPTH)-1:0] err_idx,
    output logic [WIDTH-1:0]         err_got,
    output logic [WIDTH-1:0]         err_exp,
    output logic [$clog2(DEPTH):0]   exp_count
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int TMR_W = tmr_w(TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [WIDTH-1:0]   last_q, last_d;
    logic               to_q, to_d;
    logic [IDX_W-1:0]   eidx_q, eidx_d;
    logic [WIDTH-1:0]   egot_q, egot_d;
    logic [WIDTH-1:0]   eexp_q, eexp_d;

    logic [WIDTH-1:0]   mem_rd;
    logic               wr_en;
    logic               full;
    logic [CNT_W-1:0]   cnt_wr;
    logic               sample;
    logic               hit;
    logic               last_ent;

    assign full   = (cnt_q == CNT_FULL);
    assign wr_en  = (state_q == ST_LOAD) && bus.exp_we && !full && !clr;
    assign cnt_wr = cnt_q + CNT_W'(wr_en);

    // Mode 1 treats any change of the bus as a new observation.
    assign sample = (CHANGE_MODE == 0) ? bus.obs_valid
                                       : (bus.obs_data != last_q);
    assign hit      = (bus.obs_data == mem_rd);
    assign last_ent = ({1'b0, ptr_q} == (cnt_q - CNT_W'(1)));

    sim_expect_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (cnt_q[IDX_W-1:0]),
        .wdata (bus.exp_wdata),
        .raddr (ptr_q),
        .rdata (mem_rd)
    );

    // State and verdict registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            ptr_q   <= '0;
            tmr_q   <= '0;
            last_q  <= '0;
            to_q    <= 1'b0;
            eidx_q  <= '0;
            egot_q  <= '0;
            eexp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
            last_q  <= last_d;
            to_q    <= to_d;
            eidx_q  <= eidx_d;
            egot_q  <= egot_d;
            eexp_q  <= eexp_d;
        end
    end

    // Next-state: load, run the comparison, or hold the verdict.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        tmr_d   = tmr_q;
        last_d  = last_q;
        to_d    = to_q;
        eidx_d  = eidx_q;
        egot_d  = egot_q;
        eexp_d  = eexp_q;
        if (clr) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            ptr_d   = '0;
            tmr_d   = '0;
            to_d    = 1'b0;
            eidx_d  = '0;
            egot_d  = '0;
            eexp_d  = '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    cnt_d = cnt_wr;
                    if (start) begin
                        ptr_d  = '0;
                        tmr_d  = '0;
                        last_d = '0;
                        if (cnt_wr == '0) begin
                            state_d = ST_PASS;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (sample) begin
                        last_d = bus.obs_data;
                        tmr_d  = '0;
                        if (!hit) begin
                            state_d = ST_FAIL;
                            eidx_d  = ptr_q;
                            egot_d  = bus.obs_data;
                            eexp_d  = mem_rd;
                        end else if (last_ent) begin
                            state_d = ST_PASS;
                        end else begin
                            ptr_d = ptr_q + IDX_W'(1);
                        end
                    end else if (tmr_q == TMR_LAST) begin
                        state_d = ST_FAIL;
                        to_d    = 1'b1;
                        eidx_d  = ptr_q;
                        egot_d  = '0;
                        eexp_d  = mem_rd;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_PASS: begin
                end
                ST_FAIL: begin
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign pass      = (state_q == ST_PASS);
    assign fail      = (state_q == ST_FAIL);
    assign done      = pass || fail;
    assign timeout   = to_q;
    assign err_idx   = eidx_q;
    assign err_got   = egot_q;
    assign err_exp   = eexp_q;
    assign exp_count = cnt_q;

endmodule

// File: tb/tb_sim_result_checker.sv
// Bench for sim_result_checker: directed table, corner sequences
// and randomized traffic against a list-based reference model.
module tb_sim_result_checker;

    localparam int W = 32;
    localparam int D = 8;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        clr_a [2];
    logic        st_a  [2];
    logic        we_a  [2];
    logic        ov_a  [2];
    logic [31:0] wd_a  [2];
    logic [31:0] od_a  [2];

    logic        busy_o [2];
    logic        done_o [2];
    logic        pass_o [2];
    logic        fail_o [2];
    logic        to_o   [2];
    logic [2:0]  eidx_o [2];
    logic [31:0] egot_o [2];
    logic [31:0] eexp_o [2];
    logic [3:0]  cnt_o  [2];

    sim_result_checker_if #(.WIDTH(W)) bus0 ();
    sim_result_checker_if #(.WIDTH(W)) bus1 ();

    assign bus0.exp_we    = we_a[0];
    assign bus0.exp_wdata = wd_a[0];
    assign bus0.obs_valid = ov_a[0];
    assign bus0.obs_data  = od_a[0];
    assign bus1.exp_we    = we_a[1];
    assign bus1.exp_wdata = wd_a[1];
    assign bus1.obs_valid = ov_a[1];
    assign bus1.obs_data  = od_a[1];

    sim_result_checker #(
        .WIDTH(W), .DEPTH(D), .TIMEOUT(T), .CHANGE_MODE(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr_a[0]), .start(st_a[0]),
        .bus(bus0.slave),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .fail(fail_o[0]), .timeout(to_o[0]), .err_idx(eidx_o[0]),
        .err_got(egot_o[0]), .err_exp(eexp_o[0]), .exp_count(cnt_o[0])
    );

    sim_result_checker #(
        .WIDTH(W), .DEPTH(D), .TIMEOUT(T), .CHANGE_MODE(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_a[1]), .start(st_a[1]),
        .bus(bus1.slave),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .fail(fail_o[1]), .timeout(to_o[1]), .err_idx(eidx_o[1]),
        .err_got(egot_o[1]), .err_exp(eexp_o[1]), .exp_count(cnt_o[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          clr, we;
        logic [31:0] wd;
        bit          st, ov;
        logic [31:0] od;
        bit          busy, pass, fail, to;
        int          eidx;
        logic [31:0] egot, eexp;
        int          cnt;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mkv(int c, int w, logic [31:0] wd, int s,
                                 int v, logic [31:0] od, int b, int p,
                                 int f, int t, int ei, logic [31:0] eg,
                                 logic [31:0] ee, int ec);
        vec_t r;
        r.clr = c[0];  r.we = w[0];  r.wd = wd;
        r.st = s[0];   r.ov = v[0];  r.od = od;
        r.busy = b[0]; r.pass = p[0]; r.fail = f[0]; r.to = t[0];
        r.eidx = ei;   r.egot = eg;  r.eexp = ee;  r.cnt = ec;
        return r;
    endfunction

    // Reference model: a plain list of expected values plus a verdict.
    logic [31:0] m_mem [2][8];
    int          m_cnt [2];
    int          m_pos [2];
    int          m_wait [2];
    logic [31:0] m_last [2];
    bit          m_run [2];
    bit          m_fin [2];
    bit          m_ok  [2];
    bit          m_to  [2];
    int          m_eidx [2];
    logic [31:0] m_egot [2];
    logic [31:0] m_eexp [2];

    task automatic model_clear(int m);
        m_cnt[m] = 0;  m_pos[m] = 0;  m_wait[m] = 0;
        m_run[m] = 0;  m_fin[m] = 0;  m_ok[m] = 0;  m_to[m] = 0;
        m_eidx[m] = 0; m_egot[m] = 0; m_eexp[m] = 0;
    endtask

    task automatic model_step(int m, bit c, bit w, logic [31:0] wd,
                              bit s, bit v, logic [31:0] od);
        bit seen;
        if (c) begin
            model_clear(m);
        end else if (!m_run[m] && !m_fin[m]) begin
            if (w && m_cnt[m] < D) begin
                m_mem[m][m_cnt[m]] = wd;
                m_cnt[m]++;
            end
            if (s) begin
                if (m_cnt[m] == 0) begin
                    m_fin[m] = 1; m_ok[m] = 1;
                end else begin
                    m_run[m] = 1; m_pos[m] = 0;
                    m_wait[m] = 0; m_last[m] = 0;
                end
            end
        end else if (m_run[m]) begin
            seen = (m == 0) ? v : (od != m_last[m]);
            if (seen) begin
                m_last[m] = od;
                m_wait[m] = 0;
                if (od != m_mem[m][m_pos[m]]) begin
                    m_run[m] = 0; m_fin[m] = 1; m_ok[m] = 0;
                    m_eidx[m] = m_pos[m];
                    m_egot[m] = od;
                    m_eexp[m] = m_mem[m][m_pos[m]];
                end else if (m_pos[m] == m_cnt[m] - 1) begin
                    m_run[m] = 0; m_fin[m] = 1; m_ok[m] = 1;
                end else begin
                    m_pos[m]++;
                end
            end else if (m_wait[m] + 1 == T) begin
                m_run[m] = 0; m_fin[m] = 1; m_ok[m] = 0; m_to[m] = 1;
                m_eidx[m] = m_pos[m];
                m_egot[m] = 0;
                m_eexp[m] = m_mem[m][m_pos[m]];
            end else begin
                m_wait[m]++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int m, bit c, bit w, logic [31:0] wd, bit s,
                       bit v, logic [31:0] od);
        clr_a[m] = c; we_a[m] = w; wd_a[m] = wd;
        st_a[m] = s;  ov_a[m] = v; od_a[m] = od;
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_out(int m, string tag, bit b, bit p, bit f,
                           bit t, int ei, logic [31:0] eg,
                           logic [31:0] ee, int ec);
        string u;
        u = $sformatf("%s.u%0d", tag, m);
        chk({u, ".busy"},    32'(busy_o[m]), 32'(b));
        chk({u, ".done"},    32'(done_o[m]), 32'(p | f));
        chk({u, ".pass"},    32'(pass_o[m]), 32'(p));
        chk({u, ".fail"},    32'(fail_o[m]), 32'(f));
        chk({u, ".timeout"}, 32'(to_o[m]),   32'(t));
        chk({u, ".err_idx"}, 32'(eidx_o[m]), 32'(ei));
        chk({u, ".err_got"}, egot_o[m],      eg);
        chk({u, ".err_exp"}, eexp_o[m],      ee);
        chk({u, ".count"},   32'(cnt_o[m]),  32'(ec));
    endtask

    initial begin
        logic [31:0] seq [5];
        int k;
        int vpct;
        bit c, w, s, v;
        logic [31:0] d, o;

        for (int m = 0; m < 2; m++) begin
            drv(m, 0, 0, 0, 0, 0, 0);
        end

        // Reset state.
        #1;
        chk_out(0, "reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk_out(1, "reset", 0, 0, 0, 0, 0, 0, 0, 0);
        #11 rst_n = 1'b1;
        cyc();

        // Directed table on the valid-strobe instance.
        tbl[0]  = mkv(0,1,32'h88000000,0,0,0,          0,0,0,0,0,0,0,1);
        tbl[1]  = mkv(0,0,0,1,0,0,                     1,0,0,0,0,0,0,1);
        tbl[2]  = mkv(0,0,0,0,1,32'h88000000,          0,1,0,0,0,0,0,1);
        tbl[3]  = mkv(1,0,0,0,0,0,                     0,0,0,0,0,0,0,0);
        tbl[4]  = mkv(0,1,1,0,0,0,                     0,0,0,0,0,0,0,1);
        tbl[5]  = mkv(0,1,2,0,0,0,                     0,0,0,0,0,0,0,2);
        tbl[6]  = mkv(0,1,3,0,0,0,                     0,0,0,0,0,0,0,3);
        tbl[7]  = mkv(0,0,0,1,0,0,                     1,0,0,0,0,0,0,3);
        tbl[8]  = mkv(0,0,0,0,1,1,                     1,0,0,0,0,0,0,3);
        tbl[9]  = mkv(0,0,0,0,1,5,                     0,0,1,0,1,5,2,3);
        tbl[10] = mkv(0,0,0,0,0,0,                     0,0,1,0,1,5,2,3);
        tbl[11] = mkv(0,1,4,1,1,3,                     0,0,1,0,1,5,2,3);
        tbl[12] = mkv(1,0,0,0,0,0,                     0,0,0,0,0,0,0,0);
        tbl[13] = mkv(0,1,7,1,0,0,                     1,0,0,0,0,0,0,1);
        tbl[14] = mkv(0,0,0,0,1,7,                     0,1,0,0,0,0,0,1);
        tbl[15] = mkv(1,0,0,0,0,0,                     0,0,0,0,0,0,0,0);
        tbl[16] = mkv(0,0,0,1,0,0,                     0,1,0,0,0,0,0,0);
        tbl[17] = mkv(1,0,0,0,0,0,                     0,0,0,0,0,0,0,0);
        tbl[18] = mkv(0,1,9,0,0,0,                     0,0,0,0,0,0,0,1);
        tbl[19] = mkv(0,0,0,1,0,0,                     1,0,0,0,0,0,0,1);
        tbl[20] = mkv(1,0,0,0,1,32'hdead,              0,0,0,0,0,0,0,0);

        for (int i = 0; i < 21; i++) begin
            drv(0, tbl[i].clr, tbl[i].we, tbl[i].wd, tbl[i].st,
                tbl[i].ov, tbl[i].od);
            cyc();
            chk_out(0, $sformatf("tbl%0d", i), tbl[i].busy, tbl[i].pass,
                    tbl[i].fail, tbl[i].to, tbl[i].eidx, tbl[i].egot,
                    tbl[i].eexp, tbl[i].cnt);
        end

        // Timeout: verdict appears T cycles after the start edge.
        drv(0, 0, 1, 32'hA, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 1, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0);
        k = 1;
        while (k <= T + 4) begin
            cyc();
            if (fail_o[0]) break;
            k++;
        end
        chk("tmo.cycles", 32'(k), 32'(T));
        chk_out(0, "tmo", 0, 0, 1, 1, 0, 0, 32'hA, 1);

        // Full list: ninth write dropped and never checked.
        drv(0, 1, 0, 0, 0, 0, 0);
        cyc();
        for (int i = 0; i < 9; i++) begin
            drv(0, 0, 1, 32'h100 + 32'(i), 0, 0, 0);
            cyc();
        end
        chk("full.count", 32'(cnt_o[0]), 32'(D));
        drv(0, 0, 0, 0, 1, 0, 0);
        cyc();
        for (int i = 0; i < 8; i++) begin
            drv(0, 0, 0, 0, 0, 1, 32'h100 + 32'(i));
            cyc();
            if (i < 7) chk($sformatf("full.busy%0d", i),
                           32'(busy_o[0]), 32'd1);
        end
        chk_out(0, "full", 0, 1, 0, 0, 0, 0, 0, 8);

        // Change-detect mode: repeated values are not new samples.
        drv(1, 0, 1, 32'h11, 0, 0, 0);
        cyc();
        drv(1, 0, 1, 32'h22, 0, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 1, 0, 0);
        cyc();
        seq[0] = 0; seq[1] = 0; seq[2] = 32'h11;
        seq[3] = 32'h11; seq[4] = 32'h22;
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 0, 0, 0, 1, seq[i]);
            cyc();
            if (i < 4) chk_out(1, $sformatf("chg%0d", i),
                               1, 0, 0, 0, 0, 0, 0, 2);
        end
        chk_out(1, "chg", 0, 1, 0, 0, 0, 0, 0, 2);

        // Asynchronous reset in the middle of a run.
        drv(0, 1, 0, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 1, 32'h5, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 1, 0, 0);
        cyc();
        chk("arst.busy", 32'(busy_o[0]), 32'd1);
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk_out(0, "arst", 0, 0, 0, 0, 0, 0, 0, 0);
        chk_out(1, "arst", 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        cyc();

        // Randomized traffic on both instances against the model.
        for (int m = 0; m < 2; m++) begin
            drv(m, 1, 0, 0, 0, 0, 0);
            model_clear(m);
        end
        cyc();
        for (int n = 0; n < 3000; n++) begin
            vpct = ((n / 200) % 2 == 0) ? 35 : 3;
            for (int m = 0; m < 2; m++) begin
                c = ($urandom_range(0, 99) < 2);
                w = ($urandom_range(0, 2) == 0);
                d = 32'($urandom_range(0, 15));
                s = ($urandom_range(0, 7) == 0);
                v = ($urandom_range(0, 99) < vpct);
                if (m == 1 && $urandom_range(0, 99) >= vpct) begin
                    o = od_a[1];
                end else if ($urandom_range(0, 9) < 8 &&
                             m_pos[m] < m_cnt[m]) begin
                    o = m_mem[m][m_pos[m]];
                end else begin
                    o = 32'($urandom_range(0, 15));
                end
                model_step(m, c, w, d, s, v, o);
                drv(m, c, w, d, s, v, o);
            end
            cyc();
            for (int m = 0; m < 2; m++) begin
                chk_out(m, $sformatf("rnd%0d", n), m_run[m],
                        m_fin[m] && m_ok[m], m_fin[m] && !m_ok[m],
                        m_to[m], m_eidx[m], m_egot[m], m_eexp[m],
                        m_cnt[m]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
